// File: rtl/phase_shift_ctrl.sv
// -----------------------------------------------------------------------------
// phase_shift_ctrl
//
// Bang-bang phase detector with a random-walk loop filter. Rising edges of the
// external reference (ref_i) are timed against rising edges of the divider
// output (div_i). Each completed measurement casts a vote (+1 divider lags,
// -1 divider leads, 0 coincident). FILTER_N net votes in one direction
// produce a single-cycle advance/retard pulse back to the divider.
//
// Ports:
//   clk_i            system clock, everything on the rising edge
//   reset_i          synchronous, active-high reset
//   ref_i            reference clock, asynchronous to clk_i
//   div_i            divider output, synchronous to clk_i
//   positiveShift_o  one-cycle pulse: divider lags, advance one count
//   negativeShift_o  one-cycle pulse: divider leads, retard one count
//   phaseErr_o       magnitude of the last completed measurement, in cycles
//   lead_o           sign of the last measurement, 1 = divider led reference
//   errValid_o       one-cycle strobe when phaseErr_o/lead_o are updated
//   lock_o           lock indicator
//
// Build option: define LOCK_DETECT_EN to include the lock counter; without it
// lock_o is tied to 0.
// -----------------------------------------------------------------------------
module phase_shift_ctrl #(
  parameter int FILTER_N   = 4,
  parameter int WAIT_WIDTH = 8,
  parameter int MAX_WAIT   = 200,
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_COUNT = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ref_i,
  input  logic                  div_i,
  output logic                  positiveShift_o,
  output logic                  negativeShift_o,
  output logic [WAIT_WIDTH-1:0] phaseErr_o,
  output logic                  lead_o,
  output logic                  errValid_o,
  output logic                  lock_o
);

  typedef enum logic [1:0] {IDLE, WAIT_DIV, WAIT_REF} state_t;

  localparam int ACC_W = $clog2(FILTER_N) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(FILTER_N - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [WAIT_WIDTH-1:0]   CNT_MAX = WAIT_WIDTH'(MAX_WAIT);
  localparam logic [WAIT_WIDTH-1:0]   CNT_ONE = WAIT_WIDTH'(1);

  // Legal ranges of the parameters; an illegal set elaborates this marker.
  if ((FILTER_N < 1) || (MAX_WAIT >= (1 << WAIT_WIDTH)) ||
      (LOCK_COUNT < 1) || (LOCK_TOL < 0)) begin : g_illegalConfig
  end

  logic r_refSync1, r_refSync2, r_refPrev;
  logic r_divDly1, r_divDly2, r_divPrev;
  logic w_refRise, w_divRise;

  state_t                  r_state, w_nextState;
  logic [WAIT_WIDTH-1:0]   r_cnt, w_nextCnt;
  logic                    w_measDone, w_measLead, w_votePos, w_voteNeg;
  logic [WAIT_WIDTH-1:0]   w_measErr;
  logic                    r_votePos, r_voteNeg;
  logic signed [ACC_W-1:0] r_acc;

  // ref_i is resynchronised through two flops; div_i is already in the clk_i
  // domain but gets two plain delay flops so both paths have equal latency.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_refSync1 <= 1'b0;
      r_refSync2 <= 1'b0;
      r_refPrev  <= 1'b0;
      r_divDly1  <= 1'b0;
      r_divDly2  <= 1'b0;
      r_divPrev  <= 1'b0;
    end else begin
      r_refSync1 <= ref_i;
      r_refSync2 <= r_refSync1;
      r_refPrev  <= r_refSync2;
      r_divDly1  <= div_i;
      r_divDly2  <= r_divDly1;
      r_divPrev  <= r_divDly2;
    end
  end

  assign w_refRise = r_refSync2 & ~r_refPrev;
  assign w_divRise = r_divDly2 & ~r_divPrev;

  // Measurement state and elapsed-cycle counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // A closing edge always wins over a repeated same-source edge; a repeated
  // edge alone restarts timing from the newer edge.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_measDone  = 1'b0;
    w_measErr   = r_cnt;
    w_measLead  = 1'b0;
    w_votePos   = 1'b0;
    w_voteNeg   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_refRise && w_divRise) begin
          w_measDone = 1'b1;
          w_measErr  = '0;
        end else if (w_refRise) begin
          w_nextState = WAIT_DIV;
          w_nextCnt   = CNT_ONE;
        end else if (w_divRise) begin
          w_nextState = WAIT_REF;
          w_nextCnt   = CNT_ONE;
        end
      end
      WAIT_DIV: begin
        if (w_divRise) begin
          w_measDone  = 1'b1;
          w_votePos   = 1'b1;
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else if (w_refRise) begin
          w_nextCnt = CNT_ONE;
        end else if (r_cnt == CNT_MAX) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      WAIT_REF: begin
        if (w_refRise) begin
          w_measDone  = 1'b1;
          w_measLead  = 1'b1;
          w_voteNeg   = 1'b1;
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else if (w_divRise) begin
          w_nextCnt = CNT_ONE;
        end else if (r_cnt == CNT_MAX) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Result registers; the vote is held one cycle so the filter acts after the
  // strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      errValid_o <= 1'b0;
      phaseErr_o <= '0;
      lead_o     <= 1'b0;
      r_votePos  <= 1'b0;
      r_voteNeg  <= 1'b0;
    end else begin
      errValid_o <= w_measDone;
      r_votePos  <= w_votePos;
      r_voteNeg  <= w_voteNeg;
      if (w_measDone) begin
        phaseErr_o <= w_measErr;
        lead_o     <= w_measLead;
      end
    end
  end

  // Random-walk filter: a vote arriving at the saturation level emits a pulse
  // and recentres the accumulator instead of moving it further.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_acc           <= '0;
      positiveShift_o <= 1'b0;
      negativeShift_o <= 1'b0;
    end else begin
      positiveShift_o <= 1'b0;
      negativeShift_o <= 1'b0;
      if (r_votePos) begin
        if (r_acc == ACC_MAX) begin
          positiveShift_o <= 1'b1;
          r_acc           <= '0;
        end else begin
          r_acc <= r_acc + ACC_ONE;
        end
      end else if (r_voteNeg) begin
        if (r_acc == ACC_MIN) begin
          negativeShift_o <= 1'b1;
          r_acc           <= '0;
        end else begin
          r_acc <= r_acc - ACC_ONE;
        end
      end
    end
  end

`ifdef LOCK_DETECT_EN
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LOCK_W-1:0]     LOCK_MAX = LOCK_W'(LOCK_COUNT);
  localparam logic [LOCK_W-1:0]     LOCK_ONE = LOCK_W'(1);
  localparam logic [WAIT_WIDTH-1:0] TOL      = WAIT_WIDTH'(LOCK_TOL);

  logic [LOCK_W-1:0] r_lockCnt, w_lockCntNext;
  logic              w_timeout;

  // Leaving a wait state without a completed measurement is a timeout.
  assign w_timeout = (r_state != IDLE) && (w_nextState == IDLE) && !w_measDone;

  // Count consecutive in-tolerance measurements, saturating at LOCK_COUNT.
  always_comb begin
    w_lockCntNext = r_lockCnt;
    if (w_measDone) begin
      if (w_measErr <= TOL) begin
        if (r_lockCnt != LOCK_MAX) begin
          w_lockCntNext = r_lockCnt + LOCK_ONE;
        end
      end else begin
        w_lockCntNext = '0;
      end
    end else if (w_timeout) begin
      w_lockCntNext = '0;
    end
  end

  // lock_o is registered alongside errValid_o so both change together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lockCnt <= '0;
      lock_o    <= 1'b0;
    end else begin
      r_lockCnt <= w_lockCntNext;
      lock_o    <= (w_lockCntNext == LOCK_MAX);
    end
  end
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phase_shift_ctrl
//
// Self-checking bench for phase_shift_ctrl. A timestamp-based model predicts
// every output each cycle; directed sequences add literal expectations on
// measured errors and pulse counts, followed by randomized pin activity.
// -----------------------------------------------------------------------------
module tb_phase_shift_ctrl;

  localparam int FILTER_N   = 4;
  localparam int WAIT_WIDTH = 8;
  localparam int MAX_WAIT   = 200;
  localparam int LOCK_TOL   = 1;
  localparam int LOCK_COUNT = 16;

  logic                  clk_i   = 1'b0;
  logic                  reset_i = 1'b1;
  logic                  ref_i   = 1'b0;
  logic                  div_i   = 1'b0;
  logic                  positiveShift_o, negativeShift_o;
  logic [WAIT_WIDTH-1:0] phaseErr_o;
  logic                  lead_o, errValid_o, lock_o;

  int assertCount = 0;
  int failCount   = 0;

  phase_shift_ctrl #(
    .FILTER_N  (FILTER_N),
    .WAIT_WIDTH(WAIT_WIDTH),
    .MAX_WAIT  (MAX_WAIT),
    .LOCK_TOL  (LOCK_TOL),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .ref_i          (ref_i),
    .div_i          (div_i),
    .positiveShift_o(positiveShift_o),
    .negativeShift_o(negativeShift_o),
    .phaseErr_o     (phaseErr_o),
    .lead_o         (lead_o),
    .errValid_o     (errValid_o),
    .lock_o         (lock_o)
  );

  always #5 clk_i = ~clk_i;

  // Model state: pin history, pending measurement start time, walk position.
  bit modelValid = 1'b0;
  int edgeNo = 0;
  bit refPrev, divPrev;
  bit refRiseQ[2];
  bit divRiseQ[2];
  int pend, startEdge, acc, pendVote, lockCnt;
  int expErrValid, expPhaseErr, expLead, expPos, expNeg, expLock;

  // Monitor of what the DUT actually produced, for the directed checks.
  int strobeCount = 0, posCount = 0, negCount = 0, lastErr = 0, lastLead = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit d, input bit rst);
    @(negedge clk_i);
    ref_i   = r;
    div_i   = d;
    reset_i = rst;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Reference model. A pin rise first sampled at edge n is acted on at edge
  // n+2; results appear after that edge and a vote moves the walk one edge
  // later. Errors are differences of edge timestamps.
  always @(posedge clk_i) begin
    bit rr, dr, done, timedOut;
    int err, lead, vote;
    if (reset_i) begin
      modelValid = 1'b1;
      refPrev = 0; divPrev = 0;
      refRiseQ[0] = 0; refRiseQ[1] = 0; divRiseQ[0] = 0; divRiseQ[1] = 0;
      pend = 0; startEdge = 0; acc = 0; pendVote = 0; lockCnt = 0;
      expErrValid = 0; expPhaseErr = 0; expLead = 0;
      expPos = 0; expNeg = 0; expLock = 0;
    end else begin
      rr = refRiseQ[1];
      dr = divRiseQ[1];
      refRiseQ[1] = refRiseQ[0];
      divRiseQ[1] = divRiseQ[0];
      refRiseQ[0] = ref_i && !refPrev;
      divRiseQ[0] = div_i && !divPrev;
      refPrev = ref_i;
      divPrev = div_i;

      expPos = 0;
      expNeg = 0;
      if (pendVote == 1) begin
        if (acc == FILTER_N - 1) begin expPos = 1; acc = 0; end
        else acc = acc + 1;
      end else if (pendVote == -1) begin
        if (acc == -(FILTER_N - 1)) begin expNeg = 1; acc = 0; end
        else acc = acc - 1;
      end
      pendVote = 0;

      done = 0; timedOut = 0; err = 0; lead = 0; vote = 0;
      if (pend == 0) begin
        if (rr && dr) done = 1;
        else if (rr) begin pend = 1; startEdge = edgeNo; end
        else if (dr) begin pend = 2; startEdge = edgeNo; end
      end else if (pend == 1) begin
        if (dr) begin done = 1; err = edgeNo - startEdge; vote = 1; pend = 0; end
        else if (rr) startEdge = edgeNo;
        else if (edgeNo - startEdge == MAX_WAIT) begin timedOut = 1; pend = 0; end
      end else begin
        if (rr) begin done = 1; err = edgeNo - startEdge; lead = 1; vote = -1; pend = 0; end
        else if (dr) startEdge = edgeNo;
        else if (edgeNo - startEdge == MAX_WAIT) begin timedOut = 1; pend = 0; end
      end

      expErrValid = done;
      if (done) begin
        expPhaseErr = err;
        expLead     = lead;
        pendVote    = vote;
`ifdef LOCK_DETECT_EN
        if (err <= LOCK_TOL) lockCnt = (lockCnt < LOCK_COUNT) ? lockCnt + 1 : LOCK_COUNT;
        else lockCnt = 0;
        expLock = (lockCnt == LOCK_COUNT);
`endif
      end
      if (timedOut) begin
        lockCnt = 0;
        expLock = 0;
      end
    end
    edgeNo++;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk_i) begin
    if (modelValid) begin
      checkOutput("errValid", errValid_o, expErrValid);
      checkOutput("phaseErr", phaseErr_o, expPhaseErr);
      checkOutput("lead", lead_o, expLead);
      checkOutput("positiveShift", positiveShift_o, expPos);
      checkOutput("negativeShift", negativeShift_o, expNeg);
      checkOutput("lock", lock_o, expLock);
      if (errValid_o === 1'b1) begin
        strobeCount++;
        lastErr  = phaseErr_o;
        lastLead = lead_o;
      end
      if (positiveShift_o === 1'b1) posCount++;
      if (negativeShift_o === 1'b1) negCount++;
    end
  end

  // Divider edge `delay` cycles after the reference edge (negative: before).
  task automatic measure(input int delay);
    int lead = (delay < 0) ? -delay : 0;
    int lag  = (delay > 0) ? delay : 0;
    for (int k = 0; k < lead + lag + 3; k++)
      applyStimulus(k >= lead, k >= lag, 1'b0);
    idle(8);
  endtask

  initial begin
    int sBase, pBase, nBase;
    $display("[TB] phase_shift_ctrl bench starting");

    // Reset held 5 cycles with quiet inputs.
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("resetErrValid", errValid_o, 0);
    checkOutput("resetPhaseErr", phaseErr_o, 0);
    checkOutput("resetPulses", {positiveShift_o, negativeShift_o}, 0);
    checkOutput("resetLock", lock_o, 0);
    idle(10);
    checkOutput("quietStrobes", strobeCount, 0);

    // Coincident edges: zero error, no vote.
    sBase = strobeCount; pBase = posCount; nBase = negCount;
    measure(0);
    idle(10);
    checkOutput("coincStrobe", strobeCount - sBase, 1);
    checkOutput("coincErr", lastErr, 0);
    checkOutput("coincLead", lastLead, 0);
    checkOutput("coincPulses", (posCount - pBase) + (negCount - nBase), 0);

    // Four 5-cycle lags: exactly one advance pulse.
    sBase = strobeCount; pBase = posCount;
    for (int k = 0; k < 4; k++) measure(5);
    checkOutput("lagStrobes", strobeCount - sBase, 4);
    checkOutput("lagErr", lastErr, 5);
    checkOutput("lagLead", lastLead, 0);
    checkOutput("lagPosPulses", posCount - pBase, 1);

    // Three leads then one lag: walk at -2, no pulse; two leads more: retard.
    pBase = posCount; nBase = negCount;
    for (int k = 0; k < 3; k++) measure(-3);
    checkOutput("leadErr", lastErr, 3);
    checkOutput("leadLead", lastLead, 1);
    measure(5);
    checkOutput("mixedNoPulse", (posCount - pBase) + (negCount - nBase), 0);
    measure(-3);
    measure(-3);
    checkOutput("leadNegPulses", negCount - nBase, 1);
    checkOutput("leadPosPulses", posCount - pBase, 0);

    // Reference only: timeout without strobe or pulse.
    sBase = strobeCount; pBase = posCount; nBase = negCount;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    idle(MAX_WAIT + 10);
    checkOutput("timeoutStrobes", strobeCount - sBase, 0);
    checkOutput("timeoutPulses", (posCount - pBase) + (negCount - nBase), 0);

    // Reset in the middle of a wait aborts it; a later divider edge alone
    // then only starts a new measurement.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(3);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    idle(10);
    checkOutput("abortStrobes", strobeCount - sBase, 0);
    idle(MAX_WAIT + 5);

    // Sixteen 1-cycle errors reach lock; one 3-cycle error drops it.
    for (int k = 0; k < LOCK_COUNT; k++) measure(1);
`ifdef LOCK_DETECT_EN
    checkOutput("lockSet", lock_o, 1);
`else
    checkOutput("lockSet", lock_o, 0);
`endif
    measure(3);
    checkOutput("lockDrop", lock_o, 0);

    // Randomized pin activity with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bit r, d, rs;
      r  = ref_i;
      d  = div_i;
      rs = ($urandom_range(499) == 0);
      if ($urandom_range(5) == 0) r = ~r;
      if ($urandom_range(5) == 0) d = ~d;
      applyStimulus(r, d, rs);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
